// File: rtl/fpu_cmd_sequencer.sv
// rtl/fpu_cmd_sequencer.sv - request/response front end driving the fpu 8-bit register bus
// Define FPU_SEQ_TIMEOUT_EN to enable the WAIT_END abort timer (TIMEOUT_CYCLES).
module fpu_cmd_sequencer #(
   parameter int unsigned RD_WAIT        = 1,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic        clk,
   input  logic        arst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_op,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_result,
   output logic        resp_timeout,
   output logic [7:0]  fpu_databus_out,
   input  logic [7:0]  fpu_databus_in,
   output logic [3:0]  fpu_addr,
   output logic        fpu_cs,
   output logic        fpu_rd,
   output logic        fpu_wr,
   output logic        fpu_end_ack,
   input  logic        fpu_cmd_end,
   input  logic        fpu_busy
);
   typedef enum logic [3:0] {
      S_IDLE, S_WR_A, S_WR_B, S_WR_CMD, S_WAIT_END, S_RD_RES, S_ACK, S_ABORT, S_RESP
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  idx_q, idx_d;
   logic [2:0]  wait_q, wait_d;
   logic [3:0]  op_q, op_d;
   logic [31:0] a_q, a_d, b_q, b_d, res_q, res_d;
   logic        to_q, to_d;

   logic        req_ready_q, req_ready_d;
   logic        resp_valid_q, resp_valid_d;
   logic [31:0] resp_result_q, resp_result_d;
   logic        resp_timeout_q, resp_timeout_d;
   logic [7:0]  dout_q, dout_d;
   logic [3:0]  addr_q, addr_d;
   logic        cs_q, cs_d, rd_q, rd_d, wr_q, wr_d, end_ack_q, end_ack_d;

`ifdef FPU_SEQ_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk) begin
      if (arst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end
`endif

   always_ff @(posedge clk) begin
      if (arst) begin
         state_q        <= S_IDLE;
         idx_q          <= '0;
         wait_q         <= '0;
         op_q           <= '0;
         a_q            <= '0;
         b_q            <= '0;
         res_q          <= '0;
         to_q           <= 1'b0;
         req_ready_q    <= 1'b0;
         resp_valid_q   <= 1'b0;
         resp_result_q  <= '0;
         resp_timeout_q <= 1'b0;
         dout_q         <= '0;
         addr_q         <= '0;
         cs_q           <= 1'b0;
         rd_q           <= 1'b0;
         wr_q           <= 1'b0;
         end_ack_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         idx_q          <= idx_d;
         wait_q         <= wait_d;
         op_q           <= op_d;
         a_q            <= a_d;
         b_q            <= b_d;
         res_q          <= res_d;
         to_q           <= to_d;
         req_ready_q    <= req_ready_d;
         resp_valid_q   <= resp_valid_d;
         resp_result_q  <= resp_result_d;
         resp_timeout_q <= resp_timeout_d;
         dout_q         <= dout_d;
         addr_q         <= addr_d;
         cs_q           <= cs_d;
         rd_q           <= rd_d;
         wr_q           <= wr_d;
         end_ack_q      <= end_ack_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      wait_d  = wait_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      to_d    = to_q;
`ifdef FPU_SEQ_TIMEOUT_EN
      cnt_d   = cnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (req_valid && req_ready_q) begin
               op_d    = req_op;
               a_d     = req_a;
               b_d     = req_b;
               res_d   = '0;
               to_d    = 1'b0;
               idx_d   = '0;
               state_d = S_WR_A;
            end
         end
         S_WR_A, S_WR_B: begin
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd3) state_d = (state_q == S_WR_A) ? S_WR_B : S_WR_CMD;
         end
         S_WR_CMD: begin
            state_d = S_WAIT_END;
`ifdef FPU_SEQ_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         S_WAIT_END: begin
            if (fpu_cmd_end) begin
               state_d = S_RD_RES;
               idx_d   = '0;
               wait_d  = '0;
            end
`ifdef FPU_SEQ_TIMEOUT_EN
            else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               state_d = S_ABORT;
               to_d    = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`endif
         end
         S_RD_RES: begin
            // Read data is only trusted on the last cycle of the hold window.
            if (wait_q == 3'(RD_WAIT)) begin
               res_d[{idx_q, 3'b000} +: 8] = fpu_databus_in;
               wait_d = '0;
               idx_d  = idx_q + 2'd1;
               if (idx_q == 2'd3) state_d = S_ACK;
            end else begin
               wait_d = wait_q + 3'd1;
            end
         end
         S_ACK:   if (!fpu_cmd_end) state_d = S_RESP;
         S_ABORT: state_d = S_RESP;
         S_RESP:  if (resp_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they register in step with it.
   always_comb begin
      req_ready_d    = 1'b0;
      resp_valid_d   = 1'b0;
      resp_result_d  = '0;
      resp_timeout_d = 1'b0;
      dout_d         = '0;
      addr_d         = '0;
      cs_d           = 1'b0;
      rd_d           = 1'b0;
      wr_d           = 1'b0;
      end_ack_d      = 1'b0;
      case (state_d)
         S_IDLE: req_ready_d = !fpu_busy;
         S_WR_A: begin
            cs_d   = 1'b1;
            wr_d   = 1'b1;
            addr_d = {2'b00, idx_d};
            dout_d = a_d[{idx_d, 3'b000} +: 8];
         end
         S_WR_B: begin
            cs_d   = 1'b1;
            wr_d   = 1'b1;
            addr_d = {2'b01, idx_d};
            dout_d = b_d[{idx_d, 3'b000} +: 8];
         end
         S_WR_CMD: begin
            cs_d   = 1'b1;
            wr_d   = 1'b1;
            addr_d = 4'd8;
            dout_d = {4'h0, op_d};
         end
         S_RD_RES: begin
            cs_d   = 1'b1;
            rd_d   = 1'b1;
            addr_d = 4'd9 + {2'b00, idx_d};
         end
         S_ACK, S_ABORT: end_ack_d = 1'b1;
         S_RESP: begin
            resp_valid_d   = 1'b1;
            resp_timeout_d = to_d;
            resp_result_d  = to_d ? 32'h0 : res_d;
         end
         default: ;
      endcase
   end

   assign req_ready       = req_ready_q;
   assign resp_valid      = resp_valid_q;
   assign resp_result     = resp_result_q;
   assign resp_timeout    = resp_timeout_q;
   assign fpu_databus_out = dout_q;
   assign fpu_addr        = addr_q;
   assign fpu_cs          = cs_q;
   assign fpu_rd          = rd_q;
   assign fpu_wr          = wr_q;
   assign fpu_end_ack     = end_ack_q;
endmodule

// File: tb/tb_fpu_cmd_sequencer.sv
// tb/tb_fpu_cmd_sequencer.sv - scoreboard bench for fpu_cmd_sequencer with a behavioural fpu
`timescale 1ns/1ps
module tb_fpu_cmd_sequencer;
   localparam int RD_WAIT        = 3;
   localparam int TIMEOUT_CYCLES = 16;

   logic        clk = 1'b0;
   logic        arst;
   logic        req_valid, req_ready;
   logic [3:0]  req_op;
   logic [31:0] req_a, req_b;
   logic        resp_valid, resp_ready;
   logic [31:0] resp_result;
   logic        resp_timeout;
   logic [7:0]  fpu_databus_out, fpu_databus_in;
   logic [3:0]  fpu_addr;
   logic        fpu_cs, fpu_rd, fpu_wr, fpu_end_ack, fpu_cmd_end, fpu_busy;

   fpu_cmd_sequencer #(.RD_WAIT(RD_WAIT), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
      .clk(clk), .arst(arst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_a(req_a), .req_b(req_b),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
      .resp_timeout(resp_timeout),
      .fpu_databus_out(fpu_databus_out), .fpu_databus_in(fpu_databus_in), .fpu_addr(fpu_addr),
      .fpu_cs(fpu_cs), .fpu_rd(fpu_rd), .fpu_wr(fpu_wr), .fpu_end_ack(fpu_end_ack),
      .fpu_cmd_end(fpu_cmd_end), .fpu_busy(fpu_busy)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   logic [31:0] exp_res_q[$];
   logic        exp_to_q[$];

   logic [7:0]  regs [16];
   int          wr_exp, last_wr_cyc, acc_cyc, lat, post_busy, rd_cnt, ack_len, stall_cnt;
   logic        computing, releasing, model_busy, busy_hold, busy_smp, hang, force_en, rd_prev;
   logic [31:0] force_val, fres;
   logic [3:0]  rd_addr;

   assign fpu_busy = model_busy | busy_hold;

   // Behaviour of the fake fpu: a fixed arithmetic mix of all operand bytes.
   function automatic logic [31:0] ref_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      return a * 32'd3 + (b ^ 32'h5A5A_5A5A) + {28'h0, op} * 32'h0001_1111;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_req_ready"}, req_ready, 0);
      chk({tag, "_resp_valid"}, resp_valid, 0);
      chk({tag, "_resp_result"}, resp_result, 0);
      chk({tag, "_resp_timeout"}, resp_timeout, 0);
      chk({tag, "_dout"}, fpu_databus_out, 0);
      chk({tag, "_addr"}, fpu_addr, 0);
      chk({tag, "_cs"}, fpu_cs, 0);
      chk({tag, "_rd"}, fpu_rd, 0);
      chk({tag, "_wr"}, fpu_wr, 0);
      chk({tag, "_end_ack"}, fpu_end_ack, 0);
   endtask

   task automatic model_reset();
      wr_exp = 0; rd_prev = 1'b0; rd_cnt = 0; computing = 1'b0; releasing = 1'b0;
      model_busy = 1'b0; fpu_cmd_end = 1'b0; ack_len = 0;
   endtask

   initial begin
      forever begin
         @(posedge clk);
         busy_smp = fpu_busy;
         cyc++;
      end
   end

   // fpu register-bus model and bus protocol checks
   initial begin
      int idx;
      for (int i = 0; i < 16; i++) regs[i] = 8'h00;
      fres = 32'h0; fpu_databus_in = 8'h00; acc_cyc = 0; last_wr_cyc = 0; rd_addr = 4'h0;
      model_reset();
      forever begin
         @(negedge clk);
         if (!arst) begin
            chk("bus_rd_wr_excl", fpu_rd && fpu_wr, 0);
            chk("bus_cs", fpu_cs, fpu_rd || fpu_wr);
            if (req_ready) chk("ready_vs_busy", busy_smp, 0);
            if (req_valid && req_ready) acc_cyc = cyc;
            if (fpu_wr) begin
               chk("wr_addr", fpu_addr, wr_exp);
               chk("wr_timing", cyc, (wr_exp == 0) ? acc_cyc + 1 : last_wr_cyc + 1);
               regs[fpu_addr] = fpu_databus_out;
               last_wr_cyc = cyc;
               if (fpu_addr == 4'd8) begin
                  wr_exp = 0; model_busy = 1'b1; computing = 1'b1; lat = $urandom_range(0, 8);
               end else begin
                  wr_exp++;
               end
            end
            if (computing && !hang) begin
               if (lat == 0) begin
                  fpu_cmd_end = 1'b1;
                  computing   = 1'b0;
                  fres = force_en ? force_val :
                         ref_f(regs[8][3:0], {regs[3], regs[2], regs[1], regs[0]},
                               {regs[7], regs[6], regs[5], regs[4]});
               end else begin
                  lat--;
               end
            end
            if (fpu_rd) begin
               if (rd_prev && fpu_addr == rd_addr) begin
                  rd_cnt++;
               end else begin
                  if (rd_prev) chk("rd_hold", rd_cnt, RD_WAIT);
                  chk("rd_addr", fpu_addr, rd_prev ? 32'(rd_addr) + 1 : 9);
                  rd_cnt = 0;
               end
               rd_addr = fpu_addr;
               rd_prev = 1'b1;
               idx = int'(fpu_addr) - 9;
               if (rd_cnt == RD_WAIT && idx >= 0 && idx < 4) fpu_databus_in = 8'(fres >> (8 * idx));
               else fpu_databus_in = 8'($urandom);
            end else begin
               if (rd_prev) chk("rd_hold", rd_cnt, RD_WAIT);
               rd_prev = 1'b0;
            end
            if (fpu_end_ack) begin
               ack_len++;
               fpu_cmd_end = 1'b0;
               computing   = 1'b0;
               releasing   = 1'b1;
               post_busy   = $urandom_range(0, 4);
            end else begin
               if (ack_len != 0) chk("end_ack_len", ack_len, 1);
               ack_len = 0;
               if (releasing) begin
                  if (post_busy == 0) begin model_busy = 1'b0; releasing = 1'b0; end
                  else post_busy--;
               end
            end
         end
      end
   end

   // response monitor: pops the scoreboard on every handshake
   initial begin
      logic        held, expect_drop, e_t;
      logic [31:0] held_res, e_r;
      logic        held_to;
      held = 1'b0; expect_drop = 1'b0; resp_ready = 1'b0; held_res = '0; held_to = 1'b0;
      forever begin
         @(negedge clk);
         if (arst) begin
            held = 1'b0; expect_drop = 1'b0; resp_ready = 1'b0;
         end else begin
            if (expect_drop) begin
               chk("resp_release", resp_valid, 0);
               expect_drop = 1'b0;
            end
            if (resp_valid) begin
               chk("ready_in_resp", req_ready, 0);
               if (held) begin
                  chk("resp_hold_result", resp_result, held_res);
                  chk("resp_hold_timeout", resp_timeout, held_to);
               end
               held = 1'b1; held_res = resp_result; held_to = resp_timeout;
               if (stall_cnt > 0) begin
                  stall_cnt--;
                  resp_ready = 1'b0;
               end else begin
                  resp_ready = ($urandom_range(0, 3) != 0);
               end
               if (resp_ready) begin
                  if (exp_res_q.size() == 0) begin
                     n_tests++; n_fail++;
                     $display("FAIL resp_unexpected: got %h expected no response", resp_result);
                  end else begin
                     e_r = exp_res_q.pop_front();
                     e_t = exp_to_q.pop_front();
                     chk("resp_result", resp_result, e_r);
                     chk("resp_timeout", resp_timeout, e_t);
                  end
                  held = 1'b0;
                  expect_drop = 1'b1;
               end
            end else begin
               held = 1'b0;
               resp_ready = 1'($urandom_range(0, 1));
            end
         end
      end
   end

   task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic et, input bit push);
      int t;
      t = 0;
      @(posedge clk); #1;
      req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
      @(negedge clk);
      while (!req_ready && t < 3000) begin @(negedge clk); t++; end
      if (!req_ready) begin
         n_tests++; n_fail++;
         $display("FAIL send_accept: got req_ready=0 expected 1 within 3000 cycles");
      end else if (push) begin
         exp_res_q.push_back(er);
         exp_to_q.push_back(et);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while (exp_res_q.size() != 0 && t < 5000) begin @(negedge clk); t++; end
      chk("drain_pending", exp_res_q.size(), 0);
   endtask

   task automatic wait_model_idle();
      int t;
      t = 0;
      while ((model_busy || releasing) && t < 2000) begin @(negedge clk); t++; end
      chk("model_idle", model_busy, 0);
   endtask

   initial begin
      logic [7:0]  exp_bytes [9];
      logic [3:0]  op;
      logic [31:0] a, b;
      exp_bytes = '{8'h00, 8'h00, 8'h80, 8'h3F, 8'h00, 8'h00, 8'h00, 8'h40, 8'h01};
      arst = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
      busy_hold = 1'b0; hang = 1'b0; force_en = 1'b0; force_val = '0; stall_cnt = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_zero("reset");
      @(posedge clk); #1;
      arst = 1'b0;

      // known-value operation with the fpu returning 40400000
      force_en = 1'b1; force_val = 32'h4040_0000;
      send(4'h1, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 1'b1);
      wait_drain();
      force_en = 1'b0;
      for (int i = 0; i < 9; i++) chk($sformatf("wr_byte%0d", i), regs[i], exp_bytes[i]);

      // busy fpu blocks acceptance
      wait_model_idle();
      @(posedge clk); #1; busy_hold = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b1; req_op = 4'h7; req_a = 32'h1234_5678; req_b = 32'h9ABC_DEF0;
      repeat (6) begin @(negedge clk); chk("busy_blocks_ready", req_ready, 0); end
      @(posedge clk); #1; busy_hold = 1'b0;
      @(negedge clk); chk("ready_lag", req_ready, 0);
      @(negedge clk); chk("ready_after_busy", req_ready, 1);
      exp_res_q.push_back(ref_f(4'h7, 32'h1234_5678, 32'h9ABC_DEF0));
      exp_to_q.push_back(1'b0);
      @(posedge clk); #1; req_valid = 1'b0;
      wait_drain();

      for (int i = 0; i < 20; i++) begin
         op = 4'($urandom); a = $urandom; b = $urandom;
         if (i == 0) begin a = 32'h0; b = 32'h0; op = 4'h0; end
         if (i == 1) begin a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; op = 4'hF; end
         if (i == 6) begin wait_drain(); stall_cnt = 20; end
         send(op, a, b, ref_f(op, a, b), 1'b0, 1'b1);
      end
      wait_drain();

      // reset during the B write phase discards the transaction
      wait_model_idle();
      send(4'h3, 32'hCAFE_F00D, 32'h0BAD_BEEF, 32'h0, 1'b0, 1'b0);
      begin
         int t;
         t = 0;
         while (!(fpu_wr && fpu_addr == 4'd5) && t < 200) begin @(negedge clk); t++; end
         chk("reach_wr_b1", fpu_addr, 5);
      end
      arst = 1'b1;
      @(posedge clk); #1;
      model_reset();
      @(negedge clk);
      chk_zero("mid_reset");
      @(posedge clk); #1; arst = 1'b0;
      repeat (5) @(negedge clk);
      chk("no_resp_after_reset", resp_valid, 0);
      op = 4'($urandom); a = $urandom; b = $urandom;
      send(op, a, b, ref_f(op, a, b), 1'b0, 1'b1);
      wait_drain();

`ifdef FPU_SEQ_TIMEOUT_EN
      wait_model_idle();
      hang = 1'b1;
      send(4'h2, 32'h1111_2222, 32'h3333_4444, 32'h0, 1'b1, 1'b1);
      wait_drain();
      hang = 1'b0;
`endif

      repeat (10) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/fpu_cmd_sequencer.md
# fpu_cmd_sequencer

Front-end sequencer directly upstream of the `fpu` block. Accepts one 32-bit two-operand request per transaction on a valid/ready port. Drives the FPU's 8-bit register interface byte by byte: operand A, operand B, then the command register. Waits for `cmd_end`, reads the 32-bit result back, acknowledges with `end_ack`, and returns the result on a valid/ready response port.

## Interface
Parameters:
- `RD_WAIT`, default 1: extra cycles `fpu_cs`/`fpu_rd` are held before read data is sampled (0..7).
- `TIMEOUT_CYCLES`, default 4096: cycles allowed in WAIT_END before abort (used only with `FPU_SEQ_TIMEOUT_EN`).

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `arst` in 1: reset, synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: sequencer accepts request this cycle.
- `req_op` in 4: FPU opcode, written to command register.
- `req_a` in 32: operand A.
- `req_b` in 32: operand B.
- `resp_valid` out 1: response held until `resp_ready`.
- `resp_ready` in 1: consumer takes response.
- `resp_result` out 32: FPU result.
- `resp_timeout` out 1: response is an abort; `resp_result` = 0.
- `fpu_databus_out` out 8: to FPU `databus_in`.
- `fpu_databus_in` in 8: from FPU `databus_out`.
- `fpu_addr` out 4: FPU register address.
- `fpu_cs` out 1: FPU chip select.
- `fpu_rd` out 1: FPU read strobe.
- `fpu_wr` out 1: FPU write strobe.
- `fpu_end_ack` out 1: to FPU `end_ack`.
- `fpu_cmd_end` in 1: from FPU `cmd_end`.
- `fpu_busy` in 1: from FPU `busy`.

## Operation
FPU register map, fixed:
- 0–3: A byte 0 (LSB) through byte 3.
- 4–7: B byte 0 through byte 3.
- 8: command; `{4'h0, op}`; a write starts the operation.
- 9–12: result byte 0 through byte 3, read.

States and transitions:
- IDLE: `req_ready = !fpu_busy`. On `req_valid && req_ready`, latch op/a/b, byte index = 0, go to WR_A.
- WR_A: one cycle per byte, `fpu_cs = fpu_wr = 1`, `fpu_addr = 0+idx`, data = latched A byte idx. After idx 3 go to WR_B.
- WR_B: same as WR_A, addresses 4–7. Then go to WR_CMD.
- WR_CMD: one write cycle to addr 8. Then go to WAIT_END and clear the timeout counter.
- WAIT_END: bus idle. On `fpu_cmd_end` go to RD_RES with idx = 0.
- RD_RES: `fpu_cs = fpu_rd = 1`, `fpu_addr = 9+idx`, held for RD_WAIT+1 cycles. Sample `fpu_databus_in` into result byte idx on the last held cycle. After idx 3 go to ACK.
- ACK: `fpu_end_ack = 1` until `fpu_cmd_end` is observed low, then go to RESP. Minimum 1 cycle.
- RESP: `resp_valid = 1`. On `resp_ready` return to IDLE.

Bus rules:
- `fpu_rd` and `fpu_wr` are never high together.
- `fpu_cs` is low whenever both strobes are low.
- `fpu_addr` and `fpu_databus_out` are stable for the whole strobe.

Outputs are registered. Outputs are 0 when not driven by the current state.

## Timing
- Reset value of every output is 0. This includes `req_ready`; IDLE raises it on the first cycle after reset if `fpu_busy` = 0.
- After `arst` rises, state returns to IDLE on the next edge; the in-flight transaction is discarded with no response. A mid-operation reset leaves the FPU possibly busy; IDLE holds `req_ready` low until `fpu_busy` falls.
- Accept-to-first-write: 1 cycle. Write phase: 9 consecutive cycles.
- Read phase: 4×(RD_WAIT+1) cycles. With RD_WAIT=1 it is 8 cycles.
- Overall latency: 1 + 9 + FPU time + 8 + ACK + 1 cycles to `resp_valid`.
- `cmd_end` already high in the cycle WAIT_END is entered: taken immediately.
- RESP back-pressure: result is held indefinitely; no new request is accepted while in RESP.

## Configuration
- `FPU_SEQ_TIMEOUT_EN` defined: WAIT_END counts cycles. When the count reaches TIMEOUT_CYCLES without `fpu_cmd_end`, the sequencer:
  - pulses `fpu_end_ack` for 1 cycle;
  - goes to RESP with `resp_timeout = 1` and `resp_result` = 0.
- `FPU_SEQ_TIMEOUT_EN` undefined: no counter; WAIT_END waits forever; `resp_timeout` is tied 0.

## Test plan
- Single op: a=32'h3F800000, b=32'h40000000, op=4'h1. Expect 9 write cycles with addr 0..8 and data 00,00,80,3F,00,00,00,40,01. After `cmd_end`, reads at addr 9..12 with FPU returning 00,00,40,40. Expect `resp_result` = 32'h40400000 and `resp_timeout` = 0.
- `fpu_busy` = 1 with `req_valid` = 1: `req_ready` stays 0. One cycle after busy falls, the request is accepted and the write to addr 0 follows.
- RD_WAIT=3: each read holds `cs`/`rd` for 4 cycles and samples on the 4th. Verify the result matches; changing bus data earlier in the window has no effect.
- Back-pressure: hold `resp_ready` = 0 for 20 cycles. Expect `resp_valid` and the result stable, `req_ready` = 0 throughout, and release on the first `resp_ready`.
- Reset in WR_B after B byte 1: all outputs 0 on the next edge, no response. The next request restarts at addr 0.
- With `FPU_SEQ_TIMEOUT_EN`, TIMEOUT_CYCLES=16 and `cmd_end` never asserted: a 1-cycle `end_ack`, then `resp_valid` with `resp_timeout` = 1 and `resp_result` = 0.
